pau_issue_sched: RTL and testbench
==================================

Name: pau_issue_sched

Overview:
- Issue scheduler placed between the issue stage and the Posit Arithmetic Unit datapath.
- Lets PAU operations of differing fixed latencies (0..MAX_LAT extra cycles) issue back-to-back in a pipelined fashion, instead of stalling for the whole duration of each multicycle op.
- Tracks in-flight ops in a writeback reservation table, which prevents two results landing in the same cycle.
- Enforces quire read-after-write ordering and produces the completion valid/trans_id pair for the writeback port.

Parameters:
- MAX_LAT, 2, largest extra latency of any PAU op (0 = result in the next cycle).
- TRANS_ID_BITS, 3, scoreboard transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  kill all in-flight ops (mispredict/exception).
- op_valid_i  in  1  issue stage presents an op.
- op_lat_i  in  2  extra latency class of the presented op (0..MAX_LAT).
- op_quire_i  in  1  op reads or writes the quire (QMADD, QMSUB, QCLR, QNEG, QROUND).
- op_trans_id_i  in  TRANS_ID_BITS  transaction ID of the presented op.
- op_ready_o  out  1  op may be accepted this cycle (combinational).
- issue_o  out  1  fire strobe to the datapath (= op_valid_i & op_ready_o).
- done_valid_o  out  1  result valid on the writeback port this cycle.
- done_trans_id_o  out  TRANS_ID_BITS  ID of the completing op.
- busy_o  out  1  any op in flight.

Behaviour:
- Reservation table: slots wb_q[0..MAX_LAT], each holding {valid, quire, trans_id}. Slot k means the op completes k cycles after the next clock edge.
- done_valid_o = wb_q[0].valid and done_trans_id_o = wb_q[0].trans_id. Both are flop outputs.
- busy_o = OR of all wb_q[k].valid.
- Next-state table update, every cycle:
  - wb_d[k] = wb_q[k+1] for k < MAX_LAT.
  - wb_d[MAX_LAT] is empty.
  - If issue_o, wb_d[L] = {1, op_quire_i, op_trans_id_i}, where L = op_lat_i.
- Latency: an op issued in cycle t with class L asserts done_valid_o in cycle t+1+L, for exactly one cycle.
- Structural hazard: for L < MAX_LAT the op may issue only if wb_q[L+1].valid = 0. For L = MAX_LAT there is never a slot conflict.
- Quire hazard: if op_quire_i = 1, the op may issue only if no wb_q[k] with k >= 1 has valid & quire. An op completing next cycle (k = 0) is covered by the datapath quire bypass.
- op_ready_o = !flush_i & slot_free & quire_ok. It is independent of op_valid_i, so there is no combinational loop from valid to ready.
- op_lat_i > MAX_LAT is treated as MAX_LAT.
- Completion may be out of program order; the scoreboard reorders by trans_id.
- Flush:
  - flush_i = 1 forces op_ready_o = 0.
  - All slots are cleared at the next edge, so done_valid_o = 0 from the next cycle.
  - A result already in wb_q[0] during the flush cycle is still presented in that cycle; the scoreboard discards it.
- Reset: all slots cleared. done_valid_o = 0, done_trans_id_o = 0, busy_o = 0. op_ready_o = 1 once rst_ni deasserts.
- Reset asserted mid-operation drops in-flight ops immediately (asynchronous); no completion is ever reported for them.
- There is no FSM beyond the shift table. Each of the MAX_LAT+1 slots moves only toward slot 0 and never wraps.

Test Plan:
- Pipelined single-cycle ops: three lat-0 ops with IDs 1, 2, 3 issued in cycles 0, 1, 2 -> op_ready_o stays 1; done_valid_o high in cycles 1, 2, 3 with IDs 1, 2, 3.
- Slot conflict: lat-2 op ID 4 at cycle 0, then lat-1 op ID 5 valid from cycle 1 -> op_ready_o = 0 in cycle 1; ID 5 issues in cycle 2; done ID 4 @3, ID 5 @4.
- Out-of-order completion: lat-2 op ID 1 at cycle 0, lat-0 op ID 2 at cycle 1 -> ID 2 done @2, ID 1 done @3, no stall.
- Quire chain: QMADD (lat 2, quire) IDs 6 and 7 presented back-to-back from cycle 0 -> ID 7 stalled in cycles 1-2 and issues in cycle 3; done ID 6 @3, ID 7 @6.
- Flush: lat-2 op at cycle 0, flush_i in cycle 1 with another op valid -> no issue in cycle 1; done_valid_o = 0 in cycles 2-4; busy_o = 0 from cycle 2.
- Reset mid-op: issue lat-2 op, drop rst_ni in cycle 1 -> done_valid_o and busy_o go to 0 immediately and stay 0 after release; the next op issues normally.

Source files
------------

// File: rtl/pau_issue_sched_if.sv
// Issue-stage <-> PAU scheduler handshake: op request, ready/fire, and writeback completion.
interface pau_issue_sched_if #(
  parameter int TRANS_ID_BITS = 3
);
  logic                     flush;
  logic                     op_valid;
  logic [1:0]               op_lat;
  logic                     op_quire;
  logic [TRANS_ID_BITS-1:0] op_trans_id;
  logic                     op_ready;
  logic                     issue;
  logic                     done_valid;
  logic [TRANS_ID_BITS-1:0] done_trans_id;
  logic                     busy;

  modport master (
    output flush, op_valid, op_lat, op_quire, op_trans_id,
    input  op_ready, issue, done_valid, done_trans_id, busy
  );

  modport slave (
    input  flush, op_valid, op_lat, op_quire, op_trans_id,
    output op_ready, issue, done_valid, done_trans_id, busy
  );
endinterface

// File: rtl/pau_issue_sched.sv
// Pipelined PAU issue scheduler: writeback reservation table, done = issue + 1 + latency class.
// Backpressure: op_ready drops on writeback slot conflict, pending quire write, or flush.
module pau_issue_sched #(
  parameter int MAX_LAT       = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pau_issue_sched_if.slave bus
);

  typedef struct packed {
    logic                     valid;
    logic                     quire;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } slot_t;

  localparam logic [1:0] MAX_LAT_L = 2'(MAX_LAT);

  slot_t      wb_q [MAX_LAT+1];
  slot_t      wb_d [MAX_LAT+1];
  logic [1:0] lat_eff;
  logic       slot_free;
  logic       quire_busy;
  logic       ready;
  logic       fire;
  logic       busy;

  always_comb begin
    lat_eff    = (bus.op_lat > MAX_LAT_L) ? MAX_LAT_L : bus.op_lat;
    slot_free  = 1'b1;
    quire_busy = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (lat_eff == 2'(k) && wb_q[k+1].valid) slot_free = 1'b0;
    end
    // Slot 0 is excluded: its quire result reaches the datapath through the bypass.
    for (int k = 1; k <= MAX_LAT; k++) begin
      quire_busy = quire_busy | (wb_q[k].valid & wb_q[k].quire);
    end
    ready = !bus.flush & slot_free & (!bus.op_quire | !quire_busy);
    fire  = bus.op_valid & ready;
  end

  always_comb begin
    for (int k = 0; k < MAX_LAT; k++) wb_d[k] = wb_q[k+1];
    wb_d[MAX_LAT] = '0;
    if (fire) begin
      for (int k = 0; k <= MAX_LAT; k++) begin
        if (lat_eff == 2'(k)) wb_d[k] = '{1'b1, bus.op_quire, bus.op_trans_id};
      end
    end
    if (bus.flush) begin
      for (int k = 0; k <= MAX_LAT; k++) wb_d[k] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k <= MAX_LAT; k++) wb_q[k] <= '0;
    end else begin
      for (int k = 0; k <= MAX_LAT; k++) wb_q[k] <= wb_d[k];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= MAX_LAT; k++) busy = busy | wb_q[k].valid;
  end

  assign bus.op_ready      = ready;
  assign bus.issue         = fire;
  assign bus.done_valid    = wb_q[0].valid;
  assign bus.done_trans_id = wb_q[0].trans_id;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_pau_issue_sched.sv
// Directed-vector bench for pau_issue_sched; cycle t spans posedge t to posedge t+1.
module tb_pau_issue_sched;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_bad = 0;

  pau_issue_sched_if #(.TRANS_ID_BITS(3)) bus ();

  pau_issue_sched #(.MAX_LAT(2), .TRANS_ID_BITS(3)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] l, input logic q,
                     input logic [2:0] id, input logic f);
    bus.op_valid    = v;
    bus.op_lat      = l;
    bus.op_quire    = q;
    bus.op_trans_id = id;
    bus.flush       = f;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 2'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_done(input string tag, input logic v, input logic [2:0] id);
    chk({tag, ".dv"}, 32'(bus.done_valid), 32'(v));
    if (v) chk({tag, ".id"}, 32'(bus.done_trans_id), 32'(id));
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.op_valid = 1'b0; bus.op_lat = 2'd0; bus.op_quire = 1'b0;
    bus.op_trans_id = 3'd0; bus.flush = 1'b0;
    #12;
    chk("rst.dv", 32'(bus.done_valid), 32'd0);
    chk("rst.id", 32'(bus.done_trans_id), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    rst_ni = 1'b1;
    tick();
    idle();
    chk("rst.rdy", 32'(bus.op_ready), 32'd1);

    // Pipelined lat-0 ops
    drv(1, 0, 0, 3'd1, 0); chk("p0.rdy", 32'(bus.op_ready), 1); chk("p0.iss", 32'(bus.issue), 1); chk_done("p0", 0, 0); tick();
    drv(1, 0, 0, 3'd2, 0); chk("p1.rdy", 32'(bus.op_ready), 1); chk_done("p1", 1, 3'd1); tick();
    drv(1, 0, 0, 3'd3, 0); chk("p2.rdy", 32'(bus.op_ready), 1); chk_done("p2", 1, 3'd2); tick();
    idle(); chk_done("p3", 1, 3'd3); tick();
    idle(); chk_done("p4", 0, 0); chk("p4.busy", 32'(bus.busy), 0); tick();

    // Slot conflict
    drv(1, 2, 0, 3'd4, 0); chk("s0.iss", 32'(bus.issue), 1); tick();
    drv(1, 1, 0, 3'd5, 0); chk("s1.rdy", 32'(bus.op_ready), 0); chk("s1.iss", 32'(bus.issue), 0); tick();
    drv(1, 1, 0, 3'd5, 0); chk("s2.iss", 32'(bus.issue), 1); chk_done("s2", 0, 0); tick();
    idle(); chk_done("s3", 1, 3'd4); tick();
    idle(); chk_done("s4", 1, 3'd5); tick();
    idle(); chk_done("s5", 0, 0); tick();

    // Out-of-order completion
    drv(1, 2, 0, 3'd1, 0); chk("o0.iss", 32'(bus.issue), 1); tick();
    drv(1, 0, 0, 3'd2, 0); chk("o1.iss", 32'(bus.issue), 1); chk_done("o1", 0, 0); tick();
    idle(); chk_done("o2", 1, 3'd2); tick();
    idle(); chk_done("o3", 1, 3'd1); tick();
    idle(); chk_done("o4", 0, 0); tick();

    // Quire chain
    drv(1, 2, 1, 3'd6, 0); chk("q0.iss", 32'(bus.issue), 1); tick();
    drv(1, 2, 1, 3'd7, 0); chk("q1.rdy", 32'(bus.op_ready), 0); tick();
    drv(1, 2, 1, 3'd7, 0); chk("q2.rdy", 32'(bus.op_ready), 0); tick();
    drv(1, 2, 1, 3'd7, 0); chk("q3.iss", 32'(bus.issue), 1); chk_done("q3", 1, 3'd6); tick();
    idle(); chk_done("q4", 0, 0); tick();
    idle(); chk_done("q5", 0, 0); tick();
    idle(); chk_done("q6", 1, 3'd7); tick();
    idle(); chk_done("q7", 0, 0); tick();

    // Latency class above MAX_LAT clamps to MAX_LAT
    drv(1, 3, 0, 3'd3, 0); chk("c0.iss", 32'(bus.issue), 1); tick();
    idle(); chk_done("c1", 0, 0); tick();
    idle(); chk_done("c2", 0, 0); tick();
    idle(); chk_done("c3", 1, 3'd3); tick();
    idle(); chk_done("c4", 0, 0); tick();

    // Flush
    drv(1, 2, 0, 3'd2, 0); chk("f0.iss", 32'(bus.issue), 1); tick();
    drv(1, 0, 0, 3'd3, 1); chk("f1.rdy", 32'(bus.op_ready), 0); chk("f1.iss", 32'(bus.issue), 0);
    chk("f1.busy", 32'(bus.busy), 1); tick();
    idle(); chk_done("f2", 0, 0); chk("f2.busy", 32'(bus.busy), 0); tick();
    idle(); chk_done("f3", 0, 0); chk("f3.busy", 32'(bus.busy), 0); tick();
    idle(); chk_done("f4", 0, 0); tick();

    // Reset in the middle of an op
    drv(1, 2, 0, 3'd5, 0); chk("r0.iss", 32'(bus.issue), 1); tick();
    idle(); chk("r1.busy", 32'(bus.busy), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("r1.dv", 32'(bus.done_valid), 0); chk("r1.busy0", 32'(bus.busy), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    idle(); chk_done("r2", 0, 0); chk("r2.busy", 32'(bus.busy), 0); chk("r2.rdy", 32'(bus.op_ready), 1); tick();
    idle(); chk_done("r3", 0, 0); tick();
    drv(1, 1, 0, 3'd6, 0); chk("r4.iss", 32'(bus.issue), 1); tick();
    idle(); chk_done("r5", 0, 0); tick();
    idle(); chk_done("r6", 1, 3'd6); tick();
    idle(); chk_done("r7", 0, 0); chk("r7.busy", 32'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
